// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor now, adder later).
// The optional SERIAL_SUB_OVF_EN overflow flag needs nothing from this package.
package serial_arith_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/ready handshake plus held result for the bit-serial subtractor.
// With SERIAL_SUB_OVF_EN defined the bundle also carries the signed-overflow flag ovf.
interface serial_subtractor_if
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b,
                  input  ready, busy, done, diff, borrow_out, ovf);
  modport slave  (input  start, a, b,
                  output ready, busy, done, diff, borrow_out, ovf);
`else
  modport master (output start, a, b,
                  input  ready, busy, done, diff, borrow_out);
  modport slave  (input  start, a, b,
                  output ready, busy, done, diff, borrow_out);
`endif
endinterface

// File: rtl/full_sub.sv
// 1-bit full subtractor built from two half subtractors and an OR of their borrows.
// Unaffected by SERIAL_SUB_OVF_EN.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d0, b0, b1;

  half_sub u_hs0 (.x(a),  .y(b),   .d(d0), .bout(b0));
  half_sub u_hs1 (.x(d0), .y(bin), .d(d),  .bout(b1));

  assign bout = b0 | b1;
endmodule

// File: rtl/half_sub.sv
// 1-bit half subtractor: d = x - y, bout set when x < y.
// Unaffected by SERIAL_SUB_OVF_EN.
module half_sub (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bout
);
  assign d    = x ^ y;
  assign bout = ~x & y;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full_sub cell, LSB first, WIDTH cycles per operation.
// SERIAL_SUB_OVF_EN adds a held signed-overflow flag (ovf) computed from the load-time MSBs.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic clk,
  input  logic rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sr;
  logic [WIDTH-1:0] diff_q;
  logic             bo_q;
  logic             bq;
  logic [CW-1:0]    cnt;
  logic             d, bout, last;
  logic [WIDTH-1:0] res_nxt;

  full_sub u_fs (.a(sa[0]), .b(sb[0]), .bin(bq), .d(d), .bout(bout));

  assign last    = (cnt == CW'(WIDTH - 1));
  // New bit enters at the MSB end; after WIDTH shifts the LSB has reached bit 0.
  assign res_nxt = WIDTH'({d, sr} >> 1);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_RUN;
      ST_RUN:  if (last)      state_nxt = ST_DONE;
      ST_DONE:                state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ready = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      ST_IDLE: bus.ready = 1'b1;
      ST_RUN:  bus.busy  = 1'b1;
      ST_DONE: bus.done  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      bq     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bo_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          sa  <= bus.a;
          sb  <= bus.b;
          bq  <= 1'b0;
          cnt <= '0;
        end
        ST_RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= res_nxt;
          bq  <= bout;
          cnt <= cnt + CW'(1);
          if (last) begin
            diff_q <= res_nxt;
            bo_q   <= bout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.diff       = diff_q;
  assign bus.borrow_out = bo_q;

`ifdef SERIAL_SUB_OVF_EN
  logic am, bm, ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      am    <= 1'b0;
      bm    <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state == ST_IDLE && bus.start) begin
      am <= bus.a[WIDTH-1];
      bm <= bus.b[WIDTH-1];
    end else if (state == ST_RUN && last) begin
      ovf_q <= (am != bm) && (res_nxt[WIDTH-1] != am);
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=4 and WIDTH=8 instances share one stimulus stream and
// are each compared every cycle against a timeline model; ovf is covered when SERIAL_SUB_OVF_EN is set.
module tb_serial_subtractor;
  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a     = '0;
  logic [7:0] b     = '0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(4)) if4 ();
  serial_subtractor_if #(.WIDTH(8)) if8 ();

  assign if4.start = start;
  assign if4.a     = a[3:0];
  assign if4.b     = b[3:0];
  assign if8.start = start;
  assign if8.a     = a;
  assign if8.b     = b;

  serial_subtractor #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
  serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(if8.slave));

  // ph = cycles since the accepting edge (0 = idle, 1..W = running, W+1 = done).
  typedef struct {
    int     ph;
    longint pa, pb, diff;
    bit     bo, ovf;
  } model_t;

  model_t m4 = '{default: 0};
  model_t m8 = '{default: 0};

  function automatic model_t step(input model_t m, input int w, input logic r, input logic s,
                                  input longint ai, input longint bi);
    longint md, half, xa, xb, sd;
    md   = longint'(1) << w;
    half = md / 2;
    if (r) begin
      m.ph = 0; m.diff = 0; m.bo = 0; m.ovf = 0;
    end else if (m.ph == 0) begin
      if (s) begin
        m.ph = 1; m.pa = ai % md; m.pb = bi % md;
      end
    end else if (m.ph == w + 1) begin
      m.ph = 0;
    end else begin
      m.ph++;
      if (m.ph == w + 1) begin
        m.diff = (m.pa - m.pb + md) % md;
        m.bo   = m.pa < m.pb;
        xa     = (m.pa >= half) ? m.pa - md : m.pa;
        xb     = (m.pb >= half) ? m.pb - md : m.pb;
        sd     = xa - xb;
        m.ovf  = (sd < -half) || (sd >= half);
      end
    end
    return m;
  endfunction

  always @(posedge clk) begin
    m4 = step(m4, 4, rst, start, longint'(a), longint'(b));
    m8 = step(m8, 8, rst, start, longint'(a), longint'(b));
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("u4.ready",      if4.ready,      m4.ph == 0);
    chk("u4.busy",       if4.busy,       m4.ph >= 1 && m4.ph <= 4);
    chk("u4.done",       if4.done,       m4.ph == 5);
    chk("u4.diff",       if4.diff,       m4.diff);
    chk("u4.borrow_out", if4.borrow_out, m4.bo);
    chk("u8.ready",      if8.ready,      m8.ph == 0);
    chk("u8.busy",       if8.busy,       m8.ph >= 1 && m8.ph <= 8);
    chk("u8.done",       if8.done,       m8.ph == 9);
    chk("u8.diff",       if8.diff,       m8.diff);
    chk("u8.borrow_out", if8.borrow_out, m8.bo);
`ifdef SERIAL_SUB_OVF_EN
    chk("u4.ovf",        if4.ovf,        m4.ovf);
    chk("u8.ovf",        if8.ovf,        m8.ovf);
`endif
  end

  // Called #1 after an edge with both instances idle; returns #1 after an edge with both idle.
  // mid >= 1 raises start (with operands ma/mb) for the single edge that ends cycle mid.
  task automatic op(input logic [7:0] ai, input logic [7:0] bi, input int mid,
                    input logic [7:0] ma, input logic [7:0] mb);
    int c4, c8;
    c4 = -1; c8 = -1;
    start = 1'b1; a = ai; b = bi;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c < 40 && c8 < 0; c++) begin
      @(negedge clk);
      if (c == mid) begin
        start = 1'b1; a = ma; b = mb;
      end else if (c == mid + 1) begin
        start = 1'b0;
      end
      if (if4.done === 1'b1 && c4 < 0) c4 = c;
      if (if8.done === 1'b1) c8 = c;
    end
    start = 1'b0;
    chk("u4.done_cycle", c4, 5);
    chk("u8.done_cycle", c8, 9);
    @(posedge clk); #1;
  endtask

  initial begin
    int t4[$];
    int t8[$];
    logic [7:0] ii;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready4", if4.ready, 1);
    chk("rst.busy8",  if8.busy,  0);
    chk("rst.done8",  if8.done,  0);
    chk("rst.diff8",  if8.diff,  0);
    chk("rst.bo4",    if4.borrow_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    op(8'd9, 8'd3, -1, 8'd0, 8'd0);
    chk("basic.diff4",  if4.diff, 4'd6);
    chk("basic.bo4",    if4.borrow_out, 0);
    chk("basic.model4", m4.diff, 6);
    chk("basic.diff8",  if8.diff, 8'd6);

    op(8'd3, 8'd9, -1, 8'd0, 8'd0);
    chk("borrow.diff4", if4.diff, 4'hA);
    chk("borrow.bo4",   if4.borrow_out, 1);
    chk("borrow.diff8", if8.diff, 8'hFA);
    chk("borrow.model8", m8.diff, 8'hFA);

    op(8'd0, 8'd0, -1, 8'd0, 8'd0);
    chk("zero.diff4", if4.diff, 0);
    chk("zero.bo4",   if4.borrow_out, 0);
    op(8'd15, 8'd15, -1, 8'd0, 8'd0);
    chk("max.diff4",  if4.diff, 0);
    chk("max.bo4",    if4.borrow_out, 0);
    op(8'd0, 8'd1, -1, 8'd0, 8'd0);
    chk("wrap.diff4", if4.diff, 4'hF);
    chk("wrap.bo4",   if4.borrow_out, 1);
    chk("wrap.diff8", if8.diff, 8'hFF);

    // Start pulses while running (cycle 3) and while u4 sits in DONE (cycle 5) are ignored.
    op(8'h64, 8'h1E, 3, 8'hFF, 8'h01);
    chk("ign.diff8", if8.diff, 8'h46);
    chk("ign.diff4", if4.diff, 4'h6);
    chk("ign.bo4",   if4.borrow_out, 1);
    op(8'h64, 8'h1E, 5, 8'h01, 8'hFF);
    chk("ign2.diff8", if8.diff, 8'h46);

    // Reset asserted during cycle 3 of a run.
    start = 1'b1; a = 8'hA5; b = 8'h5A;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mrst.ready8", if8.ready, 1);
    chk("mrst.busy8",  if8.busy, 0);
    chk("mrst.diff8",  if8.diff, 0);
    chk("mrst.bo8",    if8.borrow_out, 0);
    chk("mrst.ready4", if4.ready, 1);
    op(8'd200, 8'd55, -1, 8'd0, 8'd0);
    chk("mrst.after8", if8.diff, 8'd145);
    chk("mrst.afterbo8", if8.borrow_out, 0);

    // Start held high: back-to-back operations.
    start = 1'b1; a = 8'h30; b = 8'h10;
    @(posedge clk); #1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (if4.done === 1'b1) t4.push_back(c);
      if (if8.done === 1'b1) t8.push_back(c);
    end
    start = 1'b0;
    chk("b2b.count8", t8.size(), 2);
    chk("b2b.count4", t4.size(), 4);
    if (t8.size() >= 2) chk("b2b.gap8", t8[1] - t8[0], 10);
    if (t4.size() >= 2) chk("b2b.gap4", t4[1] - t4[0], 6);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (if4.ready === 1'b1 && if8.ready === 1'b1) break;
    end
    chk("b2b.drained", if4.ready === 1'b1 && if8.ready === 1'b1, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) begin
      int sel;
      sel = int'($urandom_range(0, 4));
      op(8'($urandom), 8'($urandom), (sel == 0) ? -1 : sel + 1, 8'($urandom), 8'($urandom));
    end

`ifdef SERIAL_SUB_OVF_EN
    op(8'h07, 8'h0F, -1, 8'd0, 8'd0);
    chk("ovf.diff4", if4.diff, 4'h8);
    chk("ovf.ovf4",  if4.ovf, 1);
    chk("ovf.bo4",   if4.borrow_out, 1);
    op(8'd3, 8'd2, -1, 8'd0, 8'd0);
    chk("novf.ovf4", if4.ovf, 0);
    for (int i = 0; i < 256; i++) begin
      ii = 8'(i);
      op({4'b0, ii[7:4]}, {4'b0, ii[3:0]}, -1, 8'd0, 8'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
